// File: rtl/lut_ff_mux_chk_pkg.sv
// lut_ff_mux_chk_pkg: FSM states, directed stimulus table and LFSR helper shared by the
// lut_ff_mux equivalence checker.
package lut_ff_mux_chk_pkg;
   typedef enum logic [2:0] {S_IDLE, S_APPLY, S_SETTLE, S_COMPARE, S_DONE} state_t;
   localparam int NUM_DIRECTED = 5;
   // entries are {dut_rst, dut_in[3:0], dut_mux_sel}
   localparam logic [5:0] DIR_VEC [NUM_DIRECTED] = '{6'b1_0000_0, 6'b0_0100_0, 6'b0_0100_1,
                                                      6'b0_0001_0, 6'b0_0001_1};
   localparam logic [15:0] LFSR_TAPS = 16'hB400;
   localparam logic [5:0]  IDLE_STIM = 6'b1_0000_0;
   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
   endfunction
   function automatic logic [5:0] dir_vec(input logic [2:0] i);
      return (i < 3'(NUM_DIRECTED)) ? DIR_VEC[i] : IDLE_STIM;
   endfunction
endpackage

// File: rtl/lut_ff_mux_lfsr16.sv
// lut_ff_mux_lfsr16: 16-bit Galois LFSR with seed load and advance enable; a zero seed
// is replaced by 1 so the register can never lock up.
module lut_ff_mux_lfsr16
   import lut_ff_mux_chk_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_load,
   input  logic        i_adv,
   output logic [15:0] o_state
);
   localparam logic [15:0] SEED_NZ = (SEED == 16'h0000) ? 16'h0001 : SEED;
   logic [15:0] r_state;
   always_ff @(posedge clk or negedge rst)
      if (!rst)
         r_state <= SEED_NZ;
      else if (i_load)
         r_state <= SEED_NZ;
      else if (i_adv)
         r_state <= lfsr_next(r_state);
   assign o_state = r_state;
endmodule

// File: rtl/lut_ff_mux_stim_checker.sv
// lut_ff_mux_stim_checker: drives directed then LFSR stimulus into golden and netlist
// copies of lut_ff_mux and counts Q mismatches; CHECKER_LOG_EN adds first-failure capture.
module lut_ff_mux_stim_checker
   import lut_ff_mux_chk_pkg::*;
#(
   parameter int unsigned NUM_RANDOM = 100,
   parameter logic [15:0] LFSR_SEED  = 16'hACE1,
   parameter int unsigned CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             dut_rst,
   output logic [3:0]       dut_in,
   output logic             dut_mux_sel,
   input  logic             golden_q,
   input  logic             netlist_q,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [CNT_W-1:0] mismatch_cnt,
`ifdef CHECKER_LOG_EN
   output logic [CNT_W-1:0] first_fail_idx,
   output logic [3:0]       first_fail_in,
   output logic             first_fail_sel,
   output logic             first_fail_vld,
`endif
   output logic [CNT_W-1:0] vec_cnt
);
   localparam int NUM_VEC = NUM_DIRECTED + NUM_RANDOM;
   localparam int IDX_W   = $clog2(NUM_VEC + 1);
   state_t           r_state, w_next;
   logic [IDX_W-1:0] r_idx, w_nidx;
   logic [CNT_W-1:0] r_mis, r_vec;
   logic [5:0]       r_stim, w_nstim;
   logic [15:0]      w_lfsr;
   logic [4:0]       w_rlfsr;
   logic             w_start, w_cmp, w_last, w_rand, w_mis;

   assign w_start = start && (r_state == S_IDLE || r_state == S_DONE);
   assign w_cmp   = r_state == S_COMPARE;
   assign w_last  = r_idx == IDX_W'(NUM_VEC - 1);
   assign w_rand  = r_idx >= IDX_W'(NUM_DIRECTED);
   assign w_mis   = golden_q != netlist_q;
   assign w_nidx  = r_idx + IDX_W'(1);
   // the LFSR steps on this same edge when leaving a random vector
   assign w_rlfsr = 5'(w_rand ? lfsr_next(w_lfsr) : w_lfsr);
   assign w_nstim = w_last ? IDLE_STIM :
                    (w_nidx < IDX_W'(NUM_DIRECTED)) ? dir_vec(w_nidx[2:0]) :
                    {1'b0, w_rlfsr[3:0], w_rlfsr[4]};

   lut_ff_mux_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
      .clk    (clk),
      .rst    (rst),
      .i_load (w_start),
      .i_adv  (w_cmp && w_rand),
      .o_state(w_lfsr)
   );

   always_ff @(posedge clk or negedge rst)
      if (!rst)
         r_state <= S_IDLE;
      else
         r_state <= w_next;

   always_comb begin
      w_next = w_start                ? S_APPLY   :
               (r_state == S_APPLY)   ? S_SETTLE  :
               (r_state == S_SETTLE)  ? S_COMPARE :
               w_cmp                  ? (w_last ? S_DONE : S_APPLY) :
               r_state;
   end

   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         r_idx  <= '0;
         r_stim <= IDLE_STIM;
         r_mis  <= '0;
         r_vec  <= '0;
      end else if (w_start) begin
         r_idx  <= '0;
         r_stim <= dir_vec(3'd0);
         r_mis  <= '0;
         r_vec  <= '0;
      end else if (w_cmp) begin
         r_idx  <= w_nidx;
         r_stim <= w_nstim;
         r_mis  <= r_mis + CNT_W'(w_mis && !(&r_mis));
         r_vec  <= r_vec + CNT_W'(1);
      end

   assign {dut_rst, dut_in, dut_mux_sel} = r_stim;
   assign busy         = r_state inside {S_APPLY, S_SETTLE, S_COMPARE};
   assign done         = r_state == S_DONE;
   assign pass         = done && (r_mis == '0);
   assign mismatch_cnt = r_mis;
   assign vec_cnt      = r_vec;

`ifdef CHECKER_LOG_EN
   logic [CNT_W-1:0] r_ff_idx;
   logic [3:0]       r_ff_in;
   logic             r_ff_sel, r_ff_vld;
   always_ff @(posedge clk or negedge rst)
      if (!rst || w_start) begin
         r_ff_idx <= '0;
         r_ff_in  <= '0;
         r_ff_sel <= 1'b0;
         r_ff_vld <= 1'b0;
      end else if (w_cmp && w_mis && !r_ff_vld) begin
         r_ff_idx <= CNT_W'(r_idx);
         r_ff_in  <= r_stim[4:1];
         r_ff_sel <= r_stim[0];
         r_ff_vld <= 1'b1;
      end
   assign first_fail_idx = r_ff_idx;
   assign first_fail_in  = r_ff_in;
   assign first_fail_sel = r_ff_sel;
   assign first_fail_vld = r_ff_vld;
`endif
endmodule

// File: tb/tb_lut_ff_mux_stim_checker.sv
// tb_lut_ff_mux_stim_checker: three checker instances (no random, 100 random, 2-bit counters)
// driven by a behavioural golden Q and a configurable faulty netlist Q; scoreboard checked.
module tb_lut_ff_mux_stim_checker;
   typedef struct {logic p; int mis; int vec; int cyc;} res_t;

   logic clk = 1'b0, rst = 1'b1;
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int vecs = 0, errs = 0;
   logic [2:0] st = '0, stim_en = '1, done_q = '0;
   logic [2:0] d_rst, d_sel, busy, done, pass, nq;
   logic [2:0] gq = '0;
   logic [2:0][3:0] d_in;
   logic [2:0][15:0] mis, vec;
   int mode [3];
   int s_cyc [3];
   res_t rq [3][$];
   logic [5:0] sq [3][$];
`ifdef CHECKER_LOG_EN
   logic [2:0] ffv, ffs;
   logic [2:0][3:0] ffin;
   logic [15:0] ffi0, ffi1;
   logic [1:0] ffi2;
`endif

   assign mis[2][15:2] = '0;
   assign vec[2][15:2] = '0;

   lut_ff_mux_stim_checker #(.NUM_RANDOM(0)) u_a (
      .clk(clk), .rst(rst), .start(st[0]), .dut_rst(d_rst[0]), .dut_in(d_in[0]),
      .dut_mux_sel(d_sel[0]), .golden_q(gq[0]), .netlist_q(nq[0]), .busy(busy[0]),
      .done(done[0]), .pass(pass[0]), .mismatch_cnt(mis[0]),
`ifdef CHECKER_LOG_EN
      .first_fail_idx(ffi0), .first_fail_in(ffin[0]), .first_fail_sel(ffs[0]), .first_fail_vld(ffv[0]),
`endif
      .vec_cnt(vec[0]));

   lut_ff_mux_stim_checker #(.NUM_RANDOM(100)) u_b (
      .clk(clk), .rst(rst), .start(st[1]), .dut_rst(d_rst[1]), .dut_in(d_in[1]),
      .dut_mux_sel(d_sel[1]), .golden_q(gq[1]), .netlist_q(nq[1]), .busy(busy[1]),
      .done(done[1]), .pass(pass[1]), .mismatch_cnt(mis[1]),
`ifdef CHECKER_LOG_EN
      .first_fail_idx(ffi1), .first_fail_in(ffin[1]), .first_fail_sel(ffs[1]), .first_fail_vld(ffv[1]),
`endif
      .vec_cnt(vec[1]));

   lut_ff_mux_stim_checker #(.NUM_RANDOM(0), .CNT_W(2)) u_c (
      .clk(clk), .rst(rst), .start(st[2]), .dut_rst(d_rst[2]), .dut_in(d_in[2]),
      .dut_mux_sel(d_sel[2]), .golden_q(gq[2]), .netlist_q(nq[2]), .busy(busy[2]),
      .done(done[2]), .pass(pass[2]), .mismatch_cnt(mis[2][1:0]),
`ifdef CHECKER_LOG_EN
      .first_fail_idx(ffi2), .first_fail_in(ffin[2]), .first_fail_sel(ffs[2]), .first_fail_vld(ffv[2]),
`endif
      .vec_cnt(vec[2][1:0]));

   // stand-in for lut_ff_mux: a registered mux of two input bits
   always @(posedge clk)
      for (int i = 0; i < 3; i++)
         gq[i] <= d_rst[i] ? 1'b0 : (d_sel[i] ? d_in[i][2] : d_in[i][0]);

   // mode 0: netlist equal, 1: inverted, 2: wrong only while mux_sel=1
   always_comb begin
      nq = '0;
      for (int i = 0; i < 3; i++)
         nq[i] = (mode[i] == 0) ? gq[i] : (mode[i] == 1) ? ~gq[i] : (gq[i] ^ d_sel[i]);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic push_stim(input int i, input int nrand);
      logic [5:0] dv [5] = '{6'b100000, 6'b001000, 6'b001001, 6'b000010, 6'b000011};
      logic [15:0] s = 16'hACE1;
      logic [5:0] e;
      for (int v = 0; v < 5 + nrand; v++) begin
         if (v < 5) e = dv[v];
         else begin
            e = {1'b0, s[3:0], s[4]};
            s = {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
         end
         repeat (3) sq[i].push_back(e);
      end
   endtask

   task automatic exp_res(input int i, input logic p, input int m, input int v, input int c);
      res_t r;
      r.p = p; r.mis = m; r.vec = v; r.cyc = c;
      rq[i].push_back(r);
   endtask

   task automatic go(input int i);
      @(negedge clk);
      st[i] = 1'b1;
      s_cyc[i] = cyc + 1;
      @(negedge clk);
      st[i] = 1'b0;
   endtask

   task automatic wait_done(input int i, input int lim);
      int n = 0;
      while (!done[i] && n < lim) begin
         @(negedge clk);
         n++;
      end
      chk($sformatf("done%0d_reached", i), 32'(done[i]), 1);
   endtask

   always @(negedge clk) begin
      res_t r;
      for (int i = 0; i < 3; i++) begin
         if (busy[i] && stim_en[i]) begin
            if (sq[i].size() == 0) chk($sformatf("stim%0d_extra", i), 1, 0);
            else chk($sformatf("stim%0d", i), {26'd0, d_rst[i], d_in[i], d_sel[i]}, 32'(sq[i].pop_front()));
         end
         if (done[i] && !done_q[i]) begin
            if (rq[i].size() == 0) chk($sformatf("unexpected_done%0d", i), 1, 0);
            else begin
               r = rq[i].pop_front();
               chk($sformatf("pass%0d", i), 32'(pass[i]), 32'(r.p));
               chk($sformatf("mismatch_cnt%0d", i), 32'(mis[i]), r.mis);
               chk($sformatf("vec_cnt%0d", i), 32'(vec[i]), r.vec);
               chk($sformatf("run_cycles%0d", i), cyc - s_cyc[i], r.cyc);
            end
         end
      end
      done_q = done;
   end

   initial begin
      mode = '{0, 1, 1};
      #2 rst = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("rst_dut_rst%0d", i), 32'(d_rst[i]), 1);
         chk($sformatf("rst_stim%0d", i), {27'd0, d_in[i], d_sel[i]}, 0);
         chk($sformatf("rst_flags%0d", i), {29'd0, busy[i], done[i], pass[i]}, 0);
         chk($sformatf("rst_cnts%0d", i), {mis[i], vec[i]}, 0);
      end
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      push_stim(0, 0);
      push_stim(1, 100);
      push_stim(2, 0);
      exp_res(0, 1'b1, 0, 5, 15);
      exp_res(1, 1'b0, 105, 105, 315);
      exp_res(2, 1'b0, 3, 1, 15);
      @(negedge clk);
      st = '1;
      for (int i = 0; i < 3; i++) s_cyc[i] = cyc + 1;
      @(negedge clk);
      st = '0;
      wait_done(1, 400);
      wait_done(0, 5);
      wait_done(2, 5);
`ifdef CHECKER_LOG_EN
      chk("ff_vld_clean", 32'(ffv[0]), 0);
`endif
      // restart A from DONE; a second start mid-run must be ignored
      mode[0] = 2;
      push_stim(0, 0);
      exp_res(0, 1'b0, 2, 5, 15);
      go(0);
      repeat (5) @(negedge clk);
      st[0] = 1'b1;
      @(negedge clk);
      st[0] = 1'b0;
      wait_done(0, 30);
`ifdef CHECKER_LOG_EN
      chk("ff_vld", 32'(ffv[0]), 1);
      chk("ff_idx", 32'(ffi0), 2);
      chk("ff_in", 32'(ffin[0]), 4);
      chk("ff_sel", 32'(ffs[0]), 1);
`endif
      // abandon a B run at vector 8, then rerun it from scratch
      mode[1] = 0;
      stim_en[1] = 1'b0;
      go(1);
      repeat (24) @(posedge clk);
      #1 chk("midrun_vec_cnt", 32'(vec[1]), 8);
      #1 rst = 1'b0;
      #1;
      chk("abort_flags", {29'd0, busy[1], done[1], pass[1]}, 0);
      chk("abort_stim", {26'd0, d_rst[1], d_in[1], d_sel[1]}, 32'h20);
      chk("abort_cnts", {mis[1], vec[1]}, 0);
      chk("abort_a_done", {31'd0, done[0]}, 0);
      @(negedge clk);
      rst = 1'b1;
      stim_en[1] = 1'b1;
      push_stim(1, 100);
      exp_res(1, 1'b1, 0, 105, 315);
      go(1);
      wait_done(1, 400);
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("res_queue%0d_empty", i), rq[i].size(), 0);
         chk($sformatf("stim_queue%0d_empty", i), sq[i].size(), 0);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule

// File: doc/lut_ff_mux_stim_checker.md
Name: lut_ff_mux_stim_checker

Overview:
Synthesizable on-chip equivalence checker for the lut_ff_mux test case. It drives a shared stimulus into a golden instance and a post-route netlist instance. It compares their registered Q outputs and reports a pass/fail verdict plus a mismatch count. It is the hardware counterpart of the simulation-only compare bench, so FPGA bring-up can run the same directed and random sequence on silicon.

Parameters:
NUM_RANDOM, 100, number of LFSR-generated vectors after the directed set (0 allowed)
LFSR_SEED, 16'hACE1, initial 16-bit LFSR state; a value of 0 is replaced by 16'h0001
CNT_W, 16, width of the mismatch and vector counters

Ports:
clk  in  1  single clock; drives the checker and both DUT instances
rst  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; begins a run from IDLE or DONE
dut_rst  out  1  active-high reset to both DUT instances
dut_in  out  4  shared stimulus to DUT in[3:0]
dut_mux_sel  out  1  shared stimulus to DUT mux_sel
golden_q  in  1  Q from the golden instance
netlist_q  in  1  Q from the netlist instance
busy  out  1  high from the start acceptance until DONE
done  out  1  high while in DONE
pass  out  1  valid when done=1; 1 iff mismatch_cnt==0
mismatch_cnt  out  CNT_W  count of compare failures, saturating
vec_cnt  out  CNT_W  count of vectors compared so far

Behaviour:
- Reset (rst=0, asynchronous) forces the following, also when it arrives mid-run; the run is abandoned with no partial verdict:
  - state=IDLE
  - dut_rst=1, dut_in=0, dut_mux_sel=0
  - busy=0, done=0, pass=0
  - mismatch_cnt=0, vec_cnt=0
  - LFSR=seed
- States: IDLE, APPLY, SETTLE, COMPARE, DONE.
- IDLE:
  - start=1 → APPLY with vector index 0.
  - Counters clear, LFSR reloads the seed, busy rises on the same edge.
- Vector order (index: dut_rst, dut_in, dut_mux_sel):
  - 0: 1, 0x0, 0
  - 1: 0, 0x4, 0
  - 2: 0, 0x4, 1
  - 3: 0, 0x1, 0
  - 4: 0, 0x1, 1
  - 5 .. 4+NUM_RANDOM: dut_rst=0, dut_in=LFSR[3:0], dut_mux_sel=LFSR[4]
- Stimulus outputs are registered and held stable through APPLY → SETTLE → COMPARE, one cycle each, so every vector takes 3 cycles.
- COMPARE:
  - golden_q is sampled against netlist_q on the edge leaving COMPARE.
  - Inequality increments mismatch_cnt, saturating at all-ones.
  - vec_cnt increments unconditionally.
  - If more vectors remain → APPLY with the next vector; otherwise → DONE.
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11+1. It advances only on the edge leaving COMPARE of a random vector, so random vector k uses the state after k-1 advances.
- Total run length is 3*(5+NUM_RANDOM) cycles from the start edge to done=1.
- DONE:
  - dut_rst returns to 1 and stimulus goes to 0.
  - pass, mismatch_cnt and vec_cnt are held.
  - start=1 → restart exactly as from IDLE.
- start while busy=1 is ignored.
- start coinciding with reset release is ignored; start must be sampled with rst=1 (deasserted).

Optional Feature:
CHECKER_LOG_EN:
- When defined, adds outputs:
  - first_fail_idx [CNT_W-1:0]
  - first_fail_in [3:0]
  - first_fail_sel
  - first_fail_vld
- These capture the vector index and stimulus of the first mismatch in the run.
- They are cleared at start and at reset, and held until the next start.
- When undefined, these ports and their registers are absent and behaviour is otherwise identical.

Decomposition:
- Package lut_ff_mux_chk_pkg holds:
  - the state enum
  - the directed-vector constant array (5 entries of {rst, in, sel})
  - NUM_DIRECTED=5
  - LFSR tap mask constant
- Sub-module lut_ff_mux_lfsr16: seed load, advance enable, 16-bit state output.

Test Plan:
- NUM_RANDOM=0, netlist_q tied to golden_q, start pulse → done=1 exactly 15 cycles after the start edge; pass=1, mismatch_cnt=0, vec_cnt=5.
- NUM_RANDOM=0, monitor the stimulus bus → (dut_rst, dut_in, dut_mux_sel) sequence is (1,0,0), (0,4,0), (0,4,1), (0,1,0), (0,1,1), each held 3 cycles.
- NUM_RANDOM=100, netlist_q = ~golden_q → done after 315 cycles; mismatch_cnt=105, vec_cnt=105, pass=0.
- CNT_W=2, NUM_RANDOM=0, inverted netlist → mismatch_cnt saturates at 3, vec_cnt=1 (wraps), pass=0.
- rst pulled low during vector 3, then start after release → outputs return to reset values immediately; the new run restarts from vector 0 with the same LFSR sequence as a fresh run.
- CHECKER_LOG_EN, netlist forced wrong only when dut_mux_sel=1 → first_fail_vld=1, first_fail_idx=2, first_fail_in=4'h4, first_fail_sel=1.
